// File: rtl/stratixv_tsd_reader_pkg.sv
// Shared types and constants for the Stratix V TSD reader.
package stratixv_tsd_pkg;

  localparam int TSD_DATA_W  = 8;
  localparam int AVG_SAMPLES = 4;
  localparam int AVG_ACC_W   = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    CONVERT = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4
  } state_t;

endpackage

// File: rtl/stratixv_tsd_reader_sync.sv
// Two-flop synchronizer for the TSD done flag, async active-low reset.
module stratixv_tsd_sync (
  input  logic clk,
  input  logic clrn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/stratixv_tsd_reader.sv
// Stratix V TSD controller: clear, convert, capture, valid/ready hand-off.
// Define STRATIXV_TSD_AVG_EN to average four conversions per result.
module stratixv_tsd_reader
  import stratixv_tsd_pkg::*;
#(
  parameter int CLR_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int AUTO_PERIOD    = 1000000
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  start,
  input  logic                  auto_en,
  output logic                  tsd_ce,
  output logic                  tsd_clr,
  input  logic [TSD_DATA_W-1:0] tsd_calo,
  input  logic                  tsd_caldone,
  output logic [TSD_DATA_W-1:0] temp_data,
  output logic                  temp_valid,
  input  logic                  temp_ready,
  output logic                  busy,
  output logic                  timeout_err,
  input  logic                  err_clr,
  output state_t                state_dbg
);

  // Handshake: temp_data is held while temp_valid=1; a cycle with
  // temp_valid=1 and temp_ready=1 transfers it and drops temp_valid next cycle.

  localparam int CLR_W = $clog2(CLR_CYCLES) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int PER_W = $clog2(AUTO_PERIOD) + 1;

  state_t                  state, state_next;
  logic                    done_s, done_prev, done_edge;
  logic [CLR_W-1:0]        clr_cnt;
  logic [TMO_W-1:0]        tmo_cnt;
  logic [PER_W-1:0]        per_cnt;
  logic                    per_hit, trigger, clr_last, tmo_hit, tmo_abort;
  logic                    sample_last;
  logic [TSD_DATA_W-1:0]   data_q;
  logic                    err_q;

  stratixv_tsd_sync u_sync (
    .clk  (clk),
    .clrn (clrn),
    .d    (tsd_caldone),
    .q    (done_s)
  );

  // done_prev follows done_s in every state, so a flag already high on
  // entry to CONVERT never looks like an edge.
  assign done_edge = done_s & ~done_prev;
  assign per_hit   = auto_en && (per_cnt == PER_W'(AUTO_PERIOD - 1));
  assign trigger   = start | per_hit;
  assign clr_last  = (clr_cnt == CLR_W'(CLR_CYCLES - 1));
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign tmo_abort = (state == CONVERT) && !done_edge && tmo_hit;

`ifdef STRATIXV_TSD_AVG_EN
  localparam int SMP_W = $clog2(AVG_SAMPLES) + 1;

  logic [AVG_ACC_W-1:0] acc, acc_sum;
  logic [SMP_W-1:0]     smp_cnt;

  assign acc_sum     = acc + {{(AVG_ACC_W - TSD_DATA_W){1'b0}}, tsd_calo};
  assign sample_last = (smp_cnt == SMP_W'(AVG_SAMPLES - 1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      acc     <= '0;
      smp_cnt <= '0;
    end else if (state == CAPTURE) begin
      if (sample_last) begin
        acc     <= '0;
        smp_cnt <= '0;
      end else begin
        acc     <= acc_sum;
        smp_cnt <= smp_cnt + 1'b1;
      end
    end else if (tmo_abort) begin
      acc     <= '0;
      smp_cnt <= '0;
    end
  end
`else
  assign sample_last = 1'b1;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trigger) state_next = CLEAR;
      CLEAR:   if (clr_last) state_next = CONVERT;
      CONVERT: begin
        if (done_edge)    state_next = CAPTURE;
        else if (tmo_hit) state_next = IDLE;
      end
      CAPTURE: state_next = sample_last ? HOLD : CLEAR;
      HOLD:    if (temp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      done_prev <= 1'b0;
      clr_cnt   <= '0;
      tmo_cnt   <= '0;
      per_cnt   <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_next;
      done_prev <= done_s;
      clr_cnt   <= (state == CLEAR && !clr_last) ? clr_cnt + 1'b1 : '0;
      tmo_cnt   <= (state == CONVERT) ? tmo_cnt + 1'b1 : '0;

      // Expiry is only acted on in IDLE; elsewhere the counter simply wraps.
      if (!auto_en || per_hit) per_cnt <= '0;
      else                     per_cnt <= per_cnt + 1'b1;

      if (tmo_abort)    err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;

`ifdef STRATIXV_TSD_AVG_EN
      if (state == CAPTURE && sample_last) data_q <= acc_sum[AVG_ACC_W-1:2];
`else
      if (state == CAPTURE) data_q <= tsd_calo;
`endif
    end
  end

  assign tsd_clr     = (state == CLEAR);
  assign tsd_ce      = (state == CONVERT);
  assign temp_valid  = (state == HOLD);
  assign busy        = (state != IDLE);
  assign temp_data   = data_q;
  assign timeout_err = err_q;
  assign state_dbg   = state;

endmodule
